// File: rtl/uctl_pkg.sv
// Shared constants and types for the USB controller transmit path.
// Holds token PIDs and the token transmitter state encoding.
package uctl_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PID  = 3'd1,
        ST_FLD  = 3'd2,
        ST_CRC  = 3'd3,
        ST_GAP  = 3'd4
    } tok_state_e;

    // Only OUT/IN/SETUP may be issued through the generic token port.
    function automatic logic tok_pid_legal(input logic [3:0] pid);
        return (pid[1:0] == 2'b01) && (pid != PID_SOF);
    endfunction

endpackage

// File: rtl/uctl_crc5Gen.sv
// USB CRC5 over an 11-bit token field (poly x^5+x^2+1, seed 5'h1f).
// Field bits are consumed LSB first; the raw register is returned.
module uctl_crc5Gen (
    input  logic [10:0] data_in,
    output logic [4:0]  crc_out
);

    // Bit-serial LFSR unrolled over the 11 field bits.
    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] r;
        logic       fb;
        r = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            fb = d[i] ^ r[4];
            r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return r;
    endfunction

    // Combinational CRC of the captured field.
    always_comb begin
        crc_out = crc5(data_in);
    end

endmodule

// File: rtl/uctl_token_tx_ctrl.sv
// Token/SOF packet transmitter: arbitrates requests, builds the
// 3-byte packet and serialises it to the PHY byte interface.
module uctl_token_tx_ctrl
    import uctl_pkg::*;
#(
    parameter int IPG_CYCLES = 4
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        sof_req,
    input  logic [10:0] sof_frame,
    output logic        sof_ack,
    input  logic        tok_req,
    input  logic [3:0]  tok_pid,
    input  logic [6:0]  tok_addr,
    input  logic [3:0]  tok_endp,
    output logic        tok_ack,
    output logic        tok_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        busy
);

    localparam int CW = $clog2(IPG_CYCLES + 2);
    localparam logic [CW-1:0] IPG_LD = CW'(IPG_CYCLES);

    tok_state_e    state_q, state_d;
    logic [3:0]    pid_q, pid_d;
    logic [10:0]   field_q, field_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_sop_q, tx_sop_d;
    logic          tx_eop_q, tx_eop_d;
    logic [4:0]    crc_out;
    logic          xfer;

    // The CRC only ever sees the captured field, never live inputs.
    uctl_crc5Gen u_crc5 (
        .data_in (field_q),
        .crc_out (crc_out)
    );

    assign xfer = tx_valid_q && tx_ready;

    // State, capture and output byte registers.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state_q    <= ST_IDLE;
            pid_q      <= '0;
            field_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            field_q    <= field_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
        end
    end

    // Next state: arbitration, capture, byte sequencing, gap timing.
    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        field_d = field_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sof_req) begin
                    state_d = ST_PID;
                    pid_d   = PID_SOF;
                    field_d = sof_frame;
                end else if (tok_req && tok_pid_legal(tok_pid)) begin
                    state_d = ST_PID;
                    pid_d   = tok_pid;
                    field_d = {tok_endp, tok_addr};
                end
            end
            ST_PID: if (xfer) state_d = ST_FLD;
            ST_FLD: if (xfer) state_d = ST_CRC;
            ST_CRC: begin
                if (xfer) begin
                    if (IPG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = IPG_LD;
                    end
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: acks from IDLE, next packet byte for the output flops.
    always_comb begin
        sof_ack    = 1'b0;
        tok_ack    = 1'b0;
        tok_err    = 1'b0;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_sop_d   = 1'b0;
        tx_eop_d   = 1'b0;
        if (core_rst_n && state_q == ST_IDLE) begin
            sof_ack = sof_req;
            tok_ack = !sof_req && tok_req;
            tok_err = tok_ack && !tok_pid_legal(tok_pid);
        end
        unique case (state_d)
            ST_PID: begin
                tx_data_d  = {~pid_d, pid_d};
                tx_valid_d = 1'b1;
                tx_sop_d   = 1'b1;
            end
            ST_FLD: begin
                tx_data_d  = field_d[7:0];
                tx_valid_d = 1'b1;
            end
            ST_CRC: begin
                tx_data_d  = {crc_out, field_q[10:8]};
                tx_valid_d = 1'b1;
                tx_eop_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_sop   = tx_sop_q;
    assign tx_eop   = tx_eop_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uctl_token_tx_ctrl.sv
// Directed bench for uctl_token_tx_ctrl: vector table of single
// packets plus hand sequences for stall, priority and reset cases.
module tb_uctl_token_tx_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sof_req;
    logic [10:0] sof_frame;
    logic        sof_ack;
    logic        tok_req;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        tok_ack;
    logic        tok_err;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic        busy;

    int checks = 0;
    int failures = 0;

    uctl_token_tx_ctrl #(.IPG_CYCLES(4)) dut (
        .core_clk   (clk),
        .core_rst_n (rst_n),
        .sof_req    (sof_req),
        .sof_frame  (sof_frame),
        .sof_ack    (sof_ack),
        .tok_req    (tok_req),
        .tok_pid    (tok_pid),
        .tok_addr   (tok_addr),
        .tok_endp   (tok_endp),
        .tok_ack    (tok_ack),
        .tok_err    (tok_err),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sof;
        logic [10:0] frame;
        logic        tok;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        err;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    vec_t vt[8];

    // CRC5 as polynomial long division with the seed folded into the
    // first five message bits (first-sent bit at the top).
    function automatic logic [4:0] gold_crc5(input logic [10:0] d);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < 11; i++) x[15-i] = d[i];
        x[15:11] = x[15:11] ^ 5'h1f;
        for (int i = 15; i >= 5; i--)
            if (x[i]) x = x ^ (16'h0025 << (i - 5));
        return x[4:0];
    endfunction

    function automatic logic [7:0] crc_byte(input logic [10:0] f);
        return {gold_crc5(f), f[10:8]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Advance to just after a rising edge; caller drives then waits #4.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            tick();
            #4;
            if (!busy) done = 1;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        string s;
        s = $sformatf("v%0d", n);
        tick();
        sof_req   = v.sof;
        sof_frame = v.frame;
        tok_req   = v.tok;
        tok_pid   = v.pid;
        tok_addr  = v.addr;
        tok_endp  = v.endp;
        #4;
        chk({s, "_sof_ack"}, {31'd0, sof_ack}, {31'd0, v.sof});
        chk({s, "_tok_ack"}, {31'd0, tok_ack}, {31'd0, v.tok & ~v.sof});
        chk({s, "_tok_err"}, {31'd0, tok_err}, {31'd0, v.err});
        chk({s, "_ack_valid"}, {31'd0, tx_valid}, 32'd0);
        tick();
        sof_req = 0;
        tok_req = 0;
        #4;
        if (v.err) begin
            chk({s, "_err_valid"}, {31'd0, tx_valid}, 32'd0);
            chk({s, "_err_busy"}, {31'd0, busy}, 32'd0);
        end else begin
            chk({s, "_b0"}, {21'd0, tx_valid, tx_sop, tx_eop, tx_data},
                {21'd0, 1'b1, 1'b1, 1'b0, v.b0});
            tick();
            #4;
            chk({s, "_b1"}, {21'd0, tx_valid, tx_sop, tx_eop, tx_data},
                {21'd0, 1'b1, 1'b0, 1'b0, v.b1});
            tick();
            #4;
            chk({s, "_b2"}, {21'd0, tx_valid, tx_sop, tx_eop, tx_data},
                {21'd0, 1'b1, 1'b0, 1'b1, v.b2});
            for (int g = 0; g < 4; g++) begin
                tick();
                #4;
                chk({s, "_gap"}, {30'd0, busy, tx_valid}, {30'd0, 2'b10});
            end
            tick();
            #4;
            chk({s, "_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [3:0]  lp[3];
        logic [31:0] pat;
        logic [7:0]  e[3];
        logic [7:0]  hd;
        logic        hs, he, stall;
        int          idx;

        lp[0] = 4'b0001;
        lp[1] = 4'b1001;
        lp[2] = 4'b1101;
        vt[0] = '{1'b1, 11'h000, 1'b0, 4'h0, 7'h00, 4'h0, 1'b0,
                  8'hA5, 8'h00, 8'hB8};
        vt[1] = '{1'b0, 11'h000, 1'b1, 4'hD, 7'h00, 4'h0, 1'b0,
                  8'h2D, 8'h00, 8'hB8};
        for (int i = 2; i < 5; i++) begin
            logic [3:0] p;
            logic [6:0] a;
            logic [3:0] en;
            p  = lp[$urandom_range(0, 2)];
            a  = 7'($urandom);
            en = 4'($urandom);
            vt[i] = '{1'b0, 11'h000, 1'b1, p, a, en, 1'b0,
                      {~p, p}, {en[0], a}, crc_byte({en, a})};
        end
        vt[5] = '{1'b0, 11'h000, 1'b1, 4'b0010, 7'h11, 4'h2, 1'b1,
                  8'h00, 8'h00, 8'h00};
        vt[6] = '{1'b0, 11'h000, 1'b1, 4'b0101, 7'h22, 4'h3, 1'b1,
                  8'h00, 8'h00, 8'h00};
        vt[7] = '{1'b1, 11'h5A3, 1'b0, 4'h0, 7'h00, 4'h0, 1'b0,
                  8'hA5, 8'hA3, crc_byte(11'h5A3)};

        rst_n = 0;
        sof_req = 0;
        sof_frame = '0;
        tok_req = 0;
        tok_pid = '0;
        tok_addr = '0;
        tok_endp = '0;
        tx_ready = 1;
        tick();
        tick();
        #4;
        chk("reset_outs",
            {19'd0, sof_ack, tok_ack, tok_err, tx_valid, tx_sop,
             tx_eop, busy, tx_data},
            32'd0);
        tick();
        rst_n = 1;
        #4;

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // IN token with a stalling PHY.
        pat = 32'h9617A5C2;
        e[0] = 8'h69;
        e[1] = {1'b1, 7'h3A};
        e[2] = crc_byte({4'h5, 7'h3A});
        tick();
        tok_req  = 1;
        tok_pid  = 4'b1001;
        tok_addr = 7'h3A;
        tok_endp = 4'h5;
        tx_ready = pat[0];
        #4;
        chk("stall_ack", {30'd0, tok_ack, tok_err}, {30'd0, 2'b10});
        idx = 0;
        stall = 0;
        hd = '0;
        hs = 0;
        he = 0;
        for (int c = 1; c <= 40 && idx < 3; c++) begin
            tick();
            tok_req  = 0;
            tx_ready = pat[c % 32];
            #4;
            if (tx_valid) begin
                if (stall)
                    chk("stall_stable", {22'd0, tx_sop, tx_eop, tx_data},
                        {22'd0, hs, he, hd});
                if (tx_ready) begin
                    chk("stall_byte", {22'd0, tx_sop, tx_eop, tx_data},
                        {22'd0, idx == 0, idx == 2, e[idx]});
                    idx++;
                    stall = 0;
                end else begin
                    stall = 1;
                    hd = tx_data;
                    hs = tx_sop;
                    he = tx_eop;
                end
            end
        end
        chk("stall_xfers", idx, 32'd3);
        tx_ready = 1;
        wait_idle();

        // Simultaneous requests: SOF first, token after the gap.
        tick();
        sof_req   = 1;
        sof_frame = 11'h7FF;
        tok_req   = 1;
        tok_pid   = 4'b0001;
        tok_addr  = 7'h01;
        tok_endp  = 4'h1;
        #4;
        chk("both_acks", {30'd0, sof_ack, tok_ack}, {30'd0, 2'b10});
        tick();
        sof_req = 0;
        #4;
        chk("both_sof_first", {23'd0, tx_sop, tx_data}, {23'd0, 1'b1, 8'hA5});
        for (int c = 2; c < 8; c++) begin
            tick();
            #4;
            chk("both_tok_held", {31'd0, tok_ack}, 32'd0);
        end
        tick();
        #4;
        chk("both_tok_ack", {30'd0, tok_ack, tok_err}, {30'd0, 2'b10});
        tick();
        tok_req = 0;
        #4;
        chk("both_tok_pid", {23'd0, tx_sop, tx_data}, {23'd0, 1'b1, 8'hE1});
        wait_idle();

        // Reset during the field byte abandons the packet.
        tick();
        sof_req   = 1;
        sof_frame = 11'h123;
        #4;
        chk("rst_ack", {31'd0, sof_ack}, 32'd1);
        tick();
        sof_req = 0;
        #4;
        tick();
        rst_n   = 0;
        sof_req = 1;
        #4;
        chk("rst_fld", {22'd0, tx_valid, tx_eop, tx_data},
            {22'd0, 1'b1, 1'b0, 8'h23});
        tick();
        #4;
        chk("rst_outs",
            {19'd0, sof_ack, tok_ack, tok_err, tx_valid, tx_sop,
             tx_eop, busy, tx_data},
            32'd0);
        tick();
        rst_n = 1;
        #4;
        chk("rst_reack", {31'd0, sof_ack}, 32'd1);
        tick();
        sof_req = 0;
        #4;
        chk("rst_repkt", {23'd0, tx_sop, tx_data}, {23'd0, 1'b1, 8'hA5});
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
